// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
// Entry fields are sized for the widest supported build (REGW <= 8, SELW <= 4).
package fwd_pkg;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    localparam int FWD_RD_W    = 8;
    localparam int FWD_AVAIL_W = 4;

    typedef struct packed {
        logic                   valid;
        logic [FWD_RD_W-1:0]    rd;
        logic [FWD_AVAIL_W-1:0] avail;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-read-port lookup: youngest in-flight writer of rs_i decides forward select or hazard.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int REGW  = 5,
    parameter int SELW  = $clog2(DEPTH)
) (
    input  fwd_entry_t [DEPTH-2:0] sb_i,
    input  logic [REGW-1:0]        rs_i,
    input  logic                   used_i,
    output logic [SELW-1:0]        sel_o,
    output logic                   hazard_o
);

    logic found;

    always_comb begin
        sel_o    = SELW'(FWD_RF);
        hazard_o = 1'b0;
        found    = 1'b0;
        // Lowest index is youngest; only the first match counts, even if an older one is ready.
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (!found && used_i && sb_i[j].valid && (sb_i[j].rd != '0) &&
                (sb_i[j].rd == FWD_RD_W'(rs_i))) begin
                found = 1'b1;
                if (sb_i[j].avail <= FWD_AVAIL_W'(j)) begin
                    sel_o = SELW'(j + 1);
                end else begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: shift-register scoreboard of in-flight writers,
// combinational stall, registered forward selects aligned with the EX consumer.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int REGW  = 5,
    parameter int SELW  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REGW-1:0]       id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic [SELW-1:0]       id_avail_i,
    input  logic [NREAD*REGW-1:0] id_rs_i,
    input  logic [NREAD-1:0]      id_rs_used_i,
    output logic                  stall_o,
    output logic [NREAD*SELW-1:0] fwd_o
);

    // The last tracked stage is covered by register-file write-through and is
    // never consulted, so only stages EX..DEPTH-2 are held.
    localparam int NSB = DEPTH - 1;

    fwd_entry_t [NSB-1:0]  sb_q, sb_d;
    logic [NREAD*SELW-1:0] fwd_q, fwd_d;
    logic [NREAD*SELW-1:0] sel_w;
    logic [NREAD-1:0]      haz_w;
    logic                  issue_w;

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        fwd_match #(
            .DEPTH (DEPTH),
            .REGW  (REGW),
            .SELW  (SELW)
        ) u_match (
            .sb_i     (sb_q),
            .rs_i     (id_rs_i[k*REGW +: REGW]),
            .used_i   (id_rs_used_i[k]),
            .sel_o    (sel_w[k*SELW +: SELW]),
            .hazard_o (haz_w[k])
        );
    end

    assign stall_o = id_valid_i & ~flush_i & (|haz_w);
    assign issue_w = id_valid_i & ~flush_i & ~stall_o;

    always_comb begin
        sb_d  = sb_q;
        fwd_d = fwd_q;
        if (advance_i) begin
            for (int j = 1; j < NSB; j++) begin
                sb_d[j] = sb_q[j-1];
            end
            // A stalled, flushed or empty slot enters EX as an invalid bubble.
            sb_d[0].valid = issue_w & id_regwrite_i;
            sb_d[0].rd    = FWD_RD_W'(id_rd_i);
            sb_d[0].avail = FWD_AVAIL_W'(id_avail_i);
            fwd_d         = issue_w ? sel_w : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sb_q  <= '0;
            fwd_q <= '0;
        end else begin
            sb_q  <= sb_d;
            fwd_q <= fwd_d;
        end
    end

    assign fwd_o = fwd_q;

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined CPU. It tracks in-flight register writers from EX through the last forwarding stage in a shift-register scoreboard. For every source operand of the instruction in ID it decides the forwarding source it needs when it reaches EX, or raises a stall when the producer's result cannot be ready in time (load-use and longer). Forward selects are registered, so they arrive aligned with the consumer in EX.

## Interface
- `NREAD`, default 2: source operands per instruction.
- `DEPTH`, default 3: tracked stages starting at EX (3 = EX, MEM, WB).
- `REGW`, default 5: register index width.
- `SELW`, default `$clog2(DEPTH)`: width of forward select and availability fields.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-low.
- `advance_i` input 1: pipeline advances this cycle; 0 freezes all state.
- `flush_i` input 1: squash the ID instruction (taken branch).
- `id_valid_i` input 1: ID holds a real instruction.
- `id_rd_i` input REGW: ID destination register.
- `id_regwrite_i` input 1: ID instruction writes `id_rd_i`.
- `id_avail_i` input SELW: stage offset after EX at whose end the result exists (0 = ALU, 1 = load); legal range 0..DEPTH-2.
- `id_rs_i` input NREAD*REGW: ID source registers; port k is at bits [k*REGW +: REGW].
- `id_rs_used_i` input NREAD: source k is actually read.
- `stall_o` output 1: combinational; hold IF/ID and insert a bubble.
- `fwd_o` output NREAD*SELW: registered select for the EX consumer; 0 = register file, p = forward from stage p after EX (1 = MEM, 2 = WB).

## Operation
- Scoreboard entries T[0..DEPTH-1] each hold {valid, rd, avail}. T[0] is the instruction in EX; T[j] is j stages later.
- An entry matches source s when: valid, rd ≠ 0, and rd == s. Valid is set only if `id_regwrite_i` was 1 at issue.
- Per used source, find the youngest match j over T[0..DEPTH-2]. Matches in T[DEPTH-1] are ignored, because the register file write-through covers them.
  - No match: select 0.
  - Match with avail ≤ j: select j+1.
  - Match with avail > j: the source is hazarded.
- `stall_o` = `id_valid_i` & ~`flush_i` & (any used source hazarded).
- Issue = `id_valid_i` & ~`flush_i` & ~`stall_o`.
- On a rising edge with `advance_i`=1:
  - T[j] ← T[j-1] for j ≥ 1; the oldest entry is dropped.
  - T[0] ← {issue & `id_regwrite_i`, `id_rd_i`, `id_avail_i`}.
  - `fwd_o` ← the computed selects if issue, else all zero (bubble).
- `advance_i`=0: T and `fwd_o` hold. `stall_o` is still evaluated combinationally.
- Unused sources (`id_rs_used_i`[k]=0) never stall and get select 0.
- An `id_avail_i` value ≥ DEPTH-1 is illegal. Behaviour is undefined; the bench asserts it never happens.

## Timing
- Reset (edge with `rst_i`=0): all T.valid=0 and `fwd_o`=0. Reset takes priority over `advance_i`.
- After reset `stall_o`=0, since the scoreboard is empty and the output is combinational.
- `stall_o` has zero latency from the ID inputs. `fwd_o` becomes valid one cycle after issue, aligned with the consumer in EX.
- Load-use (DEPTH=3, load avail=1 in T[0]): one stall cycle. On the next cycle the load is in T[1] and the select is 2.
- `flush_i` together with a hazard: `stall_o`=0 and a bubble is inserted.
- Two matches: the youngest wins, even if it causes a stall while an older match would be ready.
- Reset mid-stall clears the scoreboard, so the next cycle's `stall_o` is 0.

## Structure
- Shared package `fwd_pkg` holds:
  - `FWD_RF` = 0;
  - the scoreboard entry struct {valid, rd, avail};
  - the stage-offset constants (`FWD_MEM` = 1, `FWD_WB` = 2).
- Sub-module `fwd_match` is combinational, one instance per read port. It takes the scoreboard vector and one source and returns {select, hazard}. The top level holds the scoreboard registers, the `fwd_o` registers, and the stall/issue logic.

## Test plan
- ALU back-to-back, `add x5` then `sub` reading x5 -> `stall_o`=0; next cycle `fwd_o`[0]=1 (MEM).
- Load x7, then a consumer of x7 -> `stall_o`=1 for one cycle, a bubble enters T[0], then `fwd_o`=2 (WB). Also: load, independent op, consumer -> no stall, select 2.
- Writer to x0 followed by a reader of x0 -> select 0, no stall. `id_rs_used_i`=0 on a hazarded source -> no stall.
- x3 written in T[0] and T[1] -> select 1 (youngest). Match only in T[DEPTH-1] -> select 0.
- Hazard with `flush_i`=1 -> `stall_o`=0, `fwd_o` next cycle = 0. `advance_i`=0 for 3 cycles -> T and `fwd_o` unchanged.
- Reset asserted mid load-use stall -> next edge `fwd_o`=0, `stall_o`=0. Repeat the load-use case with NREAD=3, DEPTH=4, avail=2 -> two stall cycles, then select 3.
